mmio_regfile_lite: RTL

- Parametrised AXI4-Lite MMIO register file for the camera platform. It sits behind the AXI-to-Lite converter, between the PS general-purpose port and the camera/DMA control logic.
- Generalises the fixed two-camera MMIO slave in three ways: NCAM camera command/response channels, a configurable register count, and per-byte write strobes.
- Adds independent AW/W acceptance, read-only protection, write pulses, and a maskable W1C interrupt.

---
 rtl/mmio_regfile_lite.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_regfile_lite.sv
// rtl/mmio_regfile_lite.sv - AXI4-Lite MMIO register file with camera command/response channels
module mmio_regfile_lite #(
  parameter int          NREG      = 32,
  parameter int          NCAM      = 2,
  parameter int          NDBG      = 4,
  parameter int          RESP_W    = 18,
  parameter logic [31:0] BASE_ADDR = 32'h7000_0000
) (
  input  logic                     fclk,
  input  logic                     rst_n,
  input  logic [31:0]              s_awaddr,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [31:0]              s_wdata,
  input  logic [3:0]               s_wstrb,
  input  logic                     s_wvalid,
  output logic                     s_wready,
  output logic [1:0]               s_bresp,
  output logic                     s_bvalid,
  input  logic                     s_bready,
  input  logic [31:0]              s_araddr,
  input  logic                     s_arvalid,
  output logic                     s_arready,
  output logic [31:0]              s_rdata,
  output logic [1:0]               s_rresp,
  output logic                     s_rvalid,
  input  logic                     s_rready,
  output logic [NREG*32-1:0]       regs_flat,
  output logic [NREG-1:0]          wr_pulse,
  output logic [NCAM-1:0]          cam_cmd_valid,
  input  logic [NCAM*RESP_W-1:0]   cam_resp,
  input  logic [NCAM-1:0]          cam_resp_valid,
  input  logic [NDBG*32-1:0]       debug,
  output logic                     irq
);

  localparam int B      = $clog2(NREG);
  localparam int DBG_LO = NREG - NDBG;

  localparam int K_RW   = 0;
  localparam int K_STAT = 1;
  localparam int K_RESP = 2;
  localparam int K_CNT  = 3;
  localparam int K_DBG  = 4;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Elaboration-time classification of each register index
  function automatic int reg_kind(input int i);
    if (i >= DBG_LO) return K_DBG;
    if (i == 1) return K_STAT;
    if (i >= 4 && i < 4 + 3 * NCAM) begin
      if ((i - 4) % 3 == 1) return K_RESP;
      if ((i - 4) % 3 == 2) return K_CNT;
    end
    return K_RW;
  endfunction

  function automatic logic [NREG-1:0] ro_mask_f();
    logic [NREG-1:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++) begin
      m[i] = (reg_kind(i) == K_RESP) || (reg_kind(i) == K_CNT) || (reg_kind(i) == K_DBG);
    end
    return m;
  endfunction

  localparam logic [NREG-1:0] RO_MASK = ro_mask_f();

  function automatic logic addr_good(input logic [31:0] a);
    return (a[31:B+2] == BASE_ADDR[31:B+2]) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t        w_state;
  r_state_t        r_state;
  logic            aw_held;
  logic            w_held;
  logic [31:0]     awaddr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic [NREG-1:0] wr_pulse_q;
  logic            irq_q;

  logic            apply_wr;
  logic [B-1:0]    wr_idx;
  logic            wr_ok;
  logic [31:0]     wr_mask;
  logic [NREG-1:0] wr_hit;
  logic [B-1:0]    rd_idx;
  logic [NREG*32-1:0] rd_flat;

  // The write lands on the first edge where both AW and W are held
  assign apply_wr = (w_state == W_IDLE) && aw_held && w_held;
  assign wr_idx   = awaddr_q[B+1:2];
  assign wr_ok    = addr_good(awaddr_q) && !RO_MASK[wr_idx];
  assign wr_mask  = strb_mask(wstrb_q);
  assign wr_hit   = (apply_wr && wr_ok) ? (NREG'(1) << wr_idx) : '0;
  assign rd_idx   = s_araddr[B+1:2];

  // Write channel: independent AW/W capture, apply, then hold B until accepted
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      s_awready <= 1'b1;
      s_wready  <= 1'b1;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OK;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            w_state  <= W_RESP;
            s_bvalid <= 1'b1;
            s_bresp  <= wr_ok ? RESP_OK : RESP_SLVERR;
          end else begin
            if (s_awvalid && s_awready) begin
              awaddr_q  <= s_awaddr;
              aw_held   <= 1'b1;
              s_awready <= 1'b0;
            end
            if (s_wvalid && s_wready) begin
              wdata_q  <= s_wdata;
              wstrb_q  <= s_wstrb;
              w_held   <= 1'b1;
              s_wready <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (s_bready) begin
            w_state   <= W_IDLE;
            s_bvalid  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Per-index storage; debug words are wired straight through
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    localparam int KIND = reg_kind(i);
    localparam int CAM  = (i >= 4) ? (i - 4) / 3 : 0;
    if (KIND == K_DBG) begin : g_dbg
      assign rd_flat[i*32 +: 32] = debug[(i-DBG_LO)*32 +: 32];
    end else if (KIND == K_STAT) begin : g_stat
      logic [31:0] q;
      // W1C clear first, hardware set ORed on top so a same-cycle set wins
      always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else        q <= (q & ~(wr_hit[i] ? (wdata_q & wr_mask) : 32'd0)) | 32'(cam_resp_valid);
      end
      assign rd_flat[i*32 +: 32] = q;
    end else if (KIND == K_RESP) begin : g_resp
      logic [31:0] q;
      // Latch the latest camera response, zero-extended
      always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)                   q <= '0;
        else if (cam_resp_valid[CAM]) q <= 32'(cam_resp[CAM*RESP_W +: RESP_W]);
      end
      assign rd_flat[i*32 +: 32] = q;
    end else if (KIND == K_CNT) begin : g_cnt
      logic [31:0] q;
      // Free-running response counter, wraps naturally
      always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)                   q <= '0;
        else if (cam_resp_valid[CAM]) q <= q + 32'd1;
      end
      assign rd_flat[i*32 +: 32] = q;
    end else begin : g_rw
      logic [31:0] q;
      // Byte-strobed software write
      always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n)         q <= '0;
        else if (wr_hit[i]) q <= (q & ~wr_mask) | (wdata_q & wr_mask);
      end
      assign rd_flat[i*32 +: 32] = q;
    end
  end

  assign regs_flat = rd_flat;

  // One-cycle pulses trail the write by one cycle; irq trails status by one cycle
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pulse_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      wr_pulse_q <= wr_hit;
      irq_q      <= |(rd_flat[32 +: NCAM] & rd_flat[64 +: NCAM]);
    end
  end

  assign wr_pulse = wr_pulse_q;
  assign irq      = irq_q;

  for (genvar c = 0; c < NCAM; c++) begin : g_cmd
    assign cam_cmd_valid[c] = wr_pulse_q[4 + 3*c];
  end

  // Read channel: capture data on AR, hold it until R is accepted
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OK;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_arvalid) begin
            if (addr_good(s_araddr)) begin
              s_rdata <= rd_flat[rd_idx*32 +: 32];
              s_rresp <= RESP_OK;
            end else begin
              s_rdata <= '0;
              s_rresp <= RESP_SLVERR;
            end
            s_rvalid  <= 1'b1;
            s_arready <= 1'b0;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
